// File: rtl/divide_fix_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
package divide_fix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // CLAMP_ZERO encodings
  localparam int CLAMP_ZERO_OFF = 0;
  localparam int CLAMP_ZERO_ON  = 1;

  // SATURATE encodings
  localparam int SAT_WRAP  = 0;
  localparam int SAT_LIMIT = 1;

  // Ceiling log2, used to size the iteration counter.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/divide_fix_restoring_core.sv
// Radix-2 restoring division datapath: one quotient bit per cycle.
// Loaded on start; runs A_WIDTH iterations; 'last' flags the final one and
// quotient_next carries the quotient that iteration produces.
module divide_fix_restoring_core
  import divide_fix_pkg::*;
#(
  parameter int A_WIDTH = 64,
  parameter int B_WIDTH = 64
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic [A_WIDTH-1:0] dividend,
  input  logic [B_WIDTH-1:0] divisor,
  output logic               last,
  output logic [A_WIDTH-1:0] quotient_next
);

  localparam int CNT_W = (clog2(A_WIDTH) < 1) ? 1 : clog2(A_WIDTH);

  logic [B_WIDTH-1:0] rem;
  logic [A_WIDTH-1:0] q;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  logic [B_WIDTH:0]   shifted;
  logic [B_WIDTH+1:0] diff;
  logic               borrow;
  logic [B_WIDTH-1:0] rem_next;

  // Trial subtraction of the divisor from the shifted partial remainder.
  // The extra top bit of diff is the borrow; the remainder stays below the
  // divisor, so B_WIDTH bits always suffice for it.
  always_comb begin
    shifted       = {rem, q[A_WIDTH-1]};
    diff          = {1'b0, shifted} - {2'b00, divisor};
    borrow        = diff[B_WIDTH+1];
    rem_next      = borrow ? B_WIDTH'(shifted) : B_WIDTH'(diff);
    quotient_next = (q << 1) | A_WIDTH'(!borrow);
  end

  assign last = busy && (cnt == '0);

  // Load operands on start, then iterate until the counter reaches zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      q    <= dividend;
      cnt  <= CNT_W'(A_WIDTH - 1);
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_next;
      q   <= quotient_next;
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/divide_fix_seq_wrapper.sv
// Sequential unsigned divider with stream handshakes on operands and result.
// Joins the two operand channels, runs the restoring core, and forms the
// result with optional saturation and zero-to-one clamping.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting operands; decides div-by-zero once both are held
// CALC  | core iterating, one quotient bit per cycle
// DONE  | result valid and held until the consumer accepts it
module divide_fix_seq_wrapper
  import divide_fix_pkg::*;
#(
  parameter int A_WIDTH    = 64,
  parameter int B_WIDTH    = 64,
  parameter int OUT_WIDTH  = 8,
  parameter int CLAMP_ZERO = CLAMP_ZERO_ON,
  parameter int SATURATE   = SAT_WRAP
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  input  logic [A_WIDTH-1:0]   s_axis_a_tdata,
  input  logic                 s_axis_b_tvalid,
  output logic                 s_axis_b_tready,
  input  logic [B_WIDTH-1:0]   s_axis_b_tdata,
  output logic                 m_axis_result_tvalid,
  input  logic                 m_axis_result_tready,
  output logic [OUT_WIDTH-1:0] m_axis_result_tdata,
  output logic                 m_axis_result_div0,
  output logic                 m_axis_result_ovf
);

  state_t             state;
  logic               a_held;
  logic               b_held;
  logic [A_WIDTH-1:0] a_reg;
  logic [B_WIDTH-1:0] b_reg;

  logic               a_fire;
  logic               b_fire;
  logic               join_start;
  logic [A_WIDTH-1:0] dividend_mux;
  logic [B_WIDTH-1:0] divisor_mux;
  logic               core_start;
  logic               core_last;
  logic [A_WIDTH-1:0] core_q_next;

  // Packs {div0, ovf, data} for the output register.
  function automatic logic [OUT_WIDTH+1:0] form_result(input logic [A_WIDTH-1:0] qf,
                                                       input logic              div0);
    logic                 ovf;
    logic [OUT_WIDTH-1:0] r;
    logic [OUT_WIDTH-1:0] d;
    ovf = !div0 && ((qf >> OUT_WIDTH) != '0);
    r   = (SATURATE == SAT_LIMIT && ovf) ? '1 : qf[OUT_WIDTH-1:0];
    d   = (CLAMP_ZERO == CLAMP_ZERO_ON && r == '0) ? OUT_WIDTH'(1) : r;
    return {div0, ovf, d};
  endfunction

  assign s_axis_a_tready = (state == IDLE) && !a_held;
  assign s_axis_b_tready = (state == IDLE) && !b_held;
  assign a_fire          = s_axis_a_tvalid && s_axis_a_tready;
  assign b_fire          = s_axis_b_tvalid && s_axis_b_tready;

  // The core is loaded on the edge the second operand arrives, so its first
  // iteration overlaps the IDLE cycle in which div-by-zero is decided.
  always_comb begin
    dividend_mux = a_fire ? s_axis_a_tdata : a_reg;
    divisor_mux  = b_fire ? s_axis_b_tdata : b_reg;
    join_start   = (state == IDLE) && (a_held || a_fire) && (b_held || b_fire)
                   && !(a_held && b_held);
    core_start   = join_start && (divisor_mux != '0);
  end

  divide_fix_restoring_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_core (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (core_start),
    .dividend      (dividend_mux),
    .divisor       (b_reg),
    .last          (core_last),
    .quotient_next (core_q_next)
  );

  // Operand join, sequencing and the registered result.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                <= IDLE;
      a_held               <= 1'b0;
      b_held               <= 1'b0;
      a_reg                <= '0;
      b_reg                <= '0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
      m_axis_result_div0   <= 1'b0;
      m_axis_result_ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_fire) begin
            a_reg  <= s_axis_a_tdata;
            a_held <= 1'b1;
          end
          if (b_fire) begin
            b_reg  <= s_axis_b_tdata;
            b_held <= 1'b1;
          end
          if (a_held && b_held) begin
            if (b_reg == '0) begin
              {m_axis_result_div0, m_axis_result_ovf, m_axis_result_tdata}
                <= form_result('1, 1'b1);
              m_axis_result_tvalid <= 1'b1;
              state                <= DONE;
            end else if (core_last) begin
              {m_axis_result_div0, m_axis_result_ovf, m_axis_result_tdata}
                <= form_result(core_q_next, 1'b0);
              m_axis_result_tvalid <= 1'b1;
              state                <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (core_last) begin
            {m_axis_result_div0, m_axis_result_ovf, m_axis_result_tdata}
              <= form_result(core_q_next, 1'b0);
            m_axis_result_tvalid <= 1'b1;
            state                <= DONE;
          end
        end
        DONE: begin
          if (m_axis_result_tready) begin
            m_axis_result_tvalid <= 1'b0;
            a_held               <= 1'b0;
            b_held               <= 1'b0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
